// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the instruction fetch unit and the
// instruction decoder of the 8-bit MIPS datapath.
//   - fetch FSM state encoding
//   - instruction/address widths
//   - opcode field position and the HALT opcode
package mips_pkg;

   localparam int INST_W  = 16;
   localparam int ADDR_W  = 8;
   localparam int OPC_W   = 4;
   localparam int OPC_MSB = INST_W - 1;   // opcode is inst[OPC_MSB -: OPC_W]

   localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_HALT    = 3'd4
   } fetch_state_t;

   function automatic logic [OPC_W-1:0] get_opcode(input logic [INST_W-1:0] inst);
      return inst[OPC_MSB -: OPC_W];
   endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction sequencer. Holds the PC, reads a synchronous
// instruction memory (1-cycle latency) and hands each fetched word to the
// decoder with a one-cycle inst_valid strobe. Sequencing is one instruction
// per step pulse, or continuous while run_en is high; a HALT opcode stops
// the unit until reset.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   step            one-cycle fetch request (ignored unless idle)
//   run_en          level, free-run fetching while high
//   branch_en       taken-branch select, only honoured during inst_valid
//   branch_target   next PC when branch_en is honoured
//   imem_addr       memory address (held between fetches)
//   imem_rd_en      memory read enable, one cycle per fetch
//   imem_data       memory read data, valid the cycle after imem_rd_en
//   instruction     current instruction to the decoder
//   inst_valid      commit strobe, one cycle per issued instruction
//   pc              address of the next instruction to fetch
//   halted          high once HALT has been fetched
module inst_fetch_unit
   import mips_pkg::*;
#(
   parameter int               PC_WIDTH    = ADDR_W,
   parameter int               INST_WIDTH  = INST_W,
   parameter logic [OPC_W-1:0] HALT_OPCODE = OPC_HALT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  step,
   input  logic                  run_en,
   input  logic                  branch_en,
   input  logic [PC_WIDTH-1:0]   branch_target,
   output logic [PC_WIDTH-1:0]   imem_addr,
   output logic                  imem_rd_en,
   input  logic [INST_WIDTH-1:0] imem_data,
   output logic [INST_WIDTH-1:0] instruction,
   output logic                  inst_valid,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  halted
);

   fetch_state_t state, state_next;

   logic is_halt;
   logic addr_ld;
   logic inst_ld;
   logic pc_ld;

   assign is_halt = (imem_data[INST_WIDTH-1 -: OPC_W] == HALT_OPCODE);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      addr_ld    = 1'b0;
      inst_ld    = 1'b0;
      pc_ld      = 1'b0;
      imem_rd_en = 1'b0;
      inst_valid = 1'b0;
      halted     = 1'b0;
      case (state)
         ST_IDLE: begin
            // step and run_en together are a single request
            if (step | run_en) begin
               state_next = ST_FETCH;
               addr_ld    = 1'b1;   // address is registered, so load it on entry to FETCH
            end
         end
         ST_FETCH: begin
            imem_rd_en = 1'b1;
            state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (is_halt) begin
               state_next = ST_HALT;   // HALT word is never loaded or issued
            end else begin
               inst_ld    = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            inst_valid = 1'b1;
            pc_ld      = 1'b1;
            state_next = ST_IDLE;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= '0;
         instruction <= '0;
         imem_addr   <= '0;
      end else begin
         if (addr_ld) imem_addr   <= pc;
         if (inst_ld) instruction <= imem_data;
         // PC wraps modulo 2^PC_WIDTH
         if (pc_ld)   pc          <= branch_en ? branch_target : pc + PC_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a 256x16 synchronous
// ROM model. Inputs are driven and outputs sampled on the falling edge.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        step;
   logic        run_en;
   logic        branch_en;
   logic [7:0]  branch_target;
   logic [7:0]  imem_addr;
   logic        imem_rd_en;
   logic [15:0] imem_data;
   logic [15:0] instruction;
   logic        inst_valid;
   logic [7:0]  pc;
   logic        halted;

   logic [15:0] rom [256];

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (imem_rd_en) imem_data <= rom[imem_addr];

   inst_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .step          (step),
      .run_en        (run_en),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rd_en    (imem_rd_en),
      .imem_data     (imem_data),
      .instruction   (instruction),
      .inst_valid    (inst_valid),
      .pc            (pc),
      .halted        (halted)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One step from IDLE: fetch at exp_addr, issue exp_inst, then pc = exp_pc.
   task automatic do_step(input logic [7:0] exp_addr, input logic [15:0] exp_inst,
                          input logic [7:0] exp_pc, input logic br, input logic [7:0] tgt);
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      chk("fetch_rd_en", imem_rd_en, 1);
      chk("fetch_addr",  imem_addr,  exp_addr);
      @(negedge clk);
      chk("capture_no_valid", inst_valid, 0);
      @(negedge clk);
      chk("issue_valid", inst_valid, 1);
      chk("issue_inst",  instruction, exp_inst);
      branch_en = br; branch_target = tgt;
      @(negedge clk);
      branch_en = 1'b0;
      chk("after_valid_low", inst_valid, 0);
      chk("after_pc", pc, exp_pc);
   endtask

   initial begin
      logic [15:0] seen [4];
      int          seen_cyc [4];
      int          nv, nrd;

      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      rst = 1'b1; step = 1'b0; run_en = 1'b0; branch_en = 1'b0; branch_target = '0;
      imem_data = '0;

      // reset state
      do_reset();
      chk("rst_pc", pc, 0);
      chk("rst_inst", instruction, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_rd_en", imem_rd_en, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_halted", halted, 0);

      // single steps
      rom[0] = 16'h1234; rom[1] = 16'h2345;
      do_step(8'h00, 16'h1234, 8'h01, 1'b0, 8'h00);
      do_step(8'h01, 16'h2345, 8'h02, 1'b0, 8'h00);

      // free-run: valid every 4 cycles, one read per instruction
      do_reset();
      for (int i = 0; i < 4; i++) rom[i] = 16'(i + 1);
      nv = 0; nrd = 0;
      @(negedge clk); run_en = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (imem_rd_en) nrd++;
         if (inst_valid) begin
            if (nv < 4) begin seen[nv] = instruction; seen_cyc[nv] = c; end
            nv++;
         end
      end
      run_en = 1'b0;
      chk("run_valid_count", nv, 4);
      chk("run_rd_count", nrd, 4);
      for (int i = 0; i < 4 && i < nv; i++) begin
         chk("run_inst", seen[i], 16'(i + 1));
         chk("run_cycle", seen_cyc[i], 3 + 4 * i);
      end
      @(negedge clk); @(negedge clk);
      chk("run_pc", pc, 4);
      chk("run_stopped", imem_rd_en, 0);

      // branch taken during issue
      do_reset();
      rom[0] = 16'h5A00; rom[8'h40] = 16'hABCD; rom[8'h41] = 16'h1111;
      do_step(8'h00, 16'h5A00, 8'h40, 1'b1, 8'h40);
      // branch_en while idle is ignored
      @(negedge clk); branch_en = 1'b1; branch_target = 8'h10;
      @(negedge clk); branch_en = 1'b0;
      @(negedge clk);
      chk("idle_branch_pc", pc, 8'h40);
      do_step(8'h40, 16'hABCD, 8'h41, 1'b0, 8'h00);

      // wrap and halt
      rom[8'hFF] = 16'h7777; rom[0] = 16'hF000;
      do_step(8'h41, 16'h1111, 8'hFF, 1'b1, 8'hFF);
      do_step(8'hFF, 16'h7777, 8'h00, 1'b0, 8'h00);
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      chk("halt_fetch_rd", imem_rd_en, 1);
      @(negedge clk);
      chk("halt_not_yet", halted, 0);
      @(negedge clk);
      chk("halt_set", halted, 1);
      chk("halt_no_valid", inst_valid, 0);
      chk("halt_inst_kept", instruction, 16'h7777);
      chk("halt_pc", pc, 8'h00);
      nv = 0; nrd = 0;
      run_en = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step = c[0];
         @(negedge clk);
         if (inst_valid) nv++;
         if (imem_rd_en) nrd++;
      end
      step = 1'b0; run_en = 1'b0;
      chk("halt_ignore_valid", nv, 0);
      chk("halt_ignore_rd", nrd, 0);
      chk("halt_stays", halted, 1);
      chk("halt_pc_stays", pc, 8'h00);

      // reset in the CAPTURE cycle
      do_reset();
      chk("unhalt", halted, 0);
      rom[0] = 16'h1234; rom[1] = 16'h2345;
      do_step(8'h00, 16'h1234, 8'h01, 1'b0, 8'h00);
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      @(negedge clk); rst = 1'b1;           // DUT is in CAPTURE here
      @(negedge clk); rst = 1'b0;
      chk("midrst_pc", pc, 0);
      chk("midrst_inst", instruction, 0);
      chk("midrst_halted", halted, 0);
      chk("midrst_valid", inst_valid, 0);
      nv = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (inst_valid) nv++;
      end
      chk("midrst_no_valid", nv, 0);
      do_step(8'h00, 16'h1234, 8'h01, 1'b0, 8'h00);

      // step while busy is dropped
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      @(negedge clk); step = 1'b1;          // DUT is in CAPTURE here
      @(negedge clk); step = 1'b0;
      nv = 0;
      if (inst_valid) nv++;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (inst_valid) nv++;
      end
      chk("busy_one_valid", nv, 1);
      chk("busy_pc", pc, 8'h02);
      chk("busy_inst", instruction, 16'h2345);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction sequencer for the 8-bit MIPS datapath; produces the 16-bit instruction word that the instruction decoder consumes.
- Holds the PC, reads a synchronous instruction memory, and presents each fetched instruction with a one-cycle commit strobe.
- Steps one instruction per step pulse, or free-runs while run_en is high.
- Stops permanently on a HALT opcode until reset.

Parameters:
- PC_WIDTH, 8, PC and instruction-memory address width.
- INST_WIDTH, 16, instruction word width; opcode is bits [INST_WIDTH-1 -: 4].
- HALT_OPCODE, 4'hF, opcode that stops sequencing.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- step  in  1  single-cycle request to fetch and issue one instruction (already debounced and edge-detected).
- run_en  in  1  level; fetch continuously while high.
- branch_en  in  1  sampled while inst_valid=1; selects branch_target as the next PC.
- branch_target  in  PC_WIDTH  next PC when branch_en=1.
- imem_addr  out  PC_WIDTH  instruction memory address.
- imem_rd_en  out  1  instruction memory read enable.
- imem_data  in  INST_WIDTH  memory read data, valid one cycle after imem_rd_en.
- instruction  out  INST_WIDTH  current instruction to the decoder.
- inst_valid  out  1  one-cycle pulse; datapath commits the instruction in this cycle.
- pc  out  PC_WIDTH  address of the next instruction to fetch.
- halted  out  1  high once HALT has been fetched.

Behaviour:
- Reset (sync, any state): state IDLE, pc=0, instruction=0, inst_valid=0, imem_rd_en=0, imem_addr=0, halted=0. An in-flight fetch is aborted and no inst_valid is produced.
- States: IDLE, FETCH, CAPTURE, ISSUE, HALT.
- IDLE: if (step | run_en) go to FETCH; otherwise stay.
- FETCH: imem_rd_en=1, imem_addr=pc for exactly one cycle; go to CAPTURE.
- CAPTURE: imem_data is valid.
  - If opcode != HALT_OPCODE: load instruction from imem_data and go to ISSUE.
  - Else: instruction keeps its previous value and the next state is HALT.
- ISSUE: inst_valid=1 for exactly one cycle.
  - At the closing edge, pc <= branch_en ? branch_target : pc+1, then go to IDLE.
- HALT: halted=1; step and run_en are ignored; exits only on rst.
- Latency: step sampled at edge E0 -> imem_rd_en high after E0 -> instruction updated and inst_valid high after E2 (3 cycles). PC updates at E3.
- Free-run throughput: one instruction per 4 cycles (ISSUE -> IDLE -> FETCH is immediate while run_en=1).
- Outside ISSUE: inst_valid=0. Outside FETCH: imem_rd_en=0, and imem_addr holds its last value.
- PC arithmetic: modulo 2^PC_WIDTH; pc=8'hFF increments to 8'h00 with no flag.
- A step arriving while not in IDLE is dropped, not queued.
- step and run_en high together behave as a single fetch request.
- branch_en outside ISSUE is ignored.
- The HALT instruction is never issued (no inst_valid); pc stays at the HALT address.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package mips_pkg holds: the state enumeration constants, OPC_HALT, INST_W=16, ADDR_W=8, and the opcode field slice position. The inst_decoder uses the same constants.
- No sub-module is needed. A single FSM plus the PC and instruction registers is sufficient.
- For simulation, the bench supplies a behavioral 256x16 synchronous ROM model with 1-cycle latency.

Test Plan:
- Reset then single steps: ROM[0]=16'h1234, ROM[1]=16'h2345. Pulse step, then instruction=16'h1234 with inst_valid high for exactly 1 cycle, 3 cycles after step, and pc=1. A second step gives 16'h2345 and pc=2.
- Free-run: run_en=1 with ROM[0..3]=16'h0001..16'h0004. inst_valid pulses every 4 cycles carrying 0001, 0002, 0003, 0004 in order; imem_rd_en asserts exactly once per instruction.
- Branch: ROM[0]=16'h5A00; hold branch_en=1 with branch_target=8'h40 during inst_valid. Then pc=8'h40 and the next fetch drives imem_addr=8'h40. Also check that branch_en pulsed while in IDLE leaves pc unchanged.
- Wrap and halt: force pc to 8'hFF via branch, with ROM[FF]=16'h7777 and ROM[00]=16'hF000. Step issues 7777 and pc=00. The next step sets halted=1 with no inst_valid, instruction stays 7777, pc stays 00, and further steps and run_en are ignored.
- Reset mid-fetch: assert rst in the CAPTURE cycle. The next edge gives pc=0, instruction=0, halted=0, and no inst_valid. A step after rst is released fetches ROM[0] normally.
- Busy drop: pulse step while in CAPTURE. Exactly one inst_valid results, and pc advances by 1 only.
